// File: rtl/ans_serializer_pkg.sv
// ans_serializer_pkg
//   Shared definitions for the result serializer: FSM state encoding,
//   the WAIT_START timeout and the checksum seed.
//   Optional feature macro: ANS_CHECKSUM_EN adds the CSUM state.
package ans_serializer_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    STROBE     = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    NEXT       = 3'd4
`ifdef ANS_CHECKSUM_EN
    ,
    CSUM       = 3'd5
`endif
  } AnsState;

  // Cycles to wait for the uart to report busy before assuming it started.
  localparam int WAIT_START_TIMEOUT = 4;

  // Starting value of the running XOR over the data bytes.
  localparam logic [7:0] CSUM_SEED = 8'h00;

endpackage

// File: rtl/ans_byte_sel.sv
// ans_byte_sel
//   Purely combinational selection of byte k from a captured word,
//   MSB-first: byte 0 is word[N-1 -: 8].
//   Ports:
//     i_word [N-1:0]           captured result word
//     i_idx  [NBYTES_LOG2-1:0] byte index
//     o_byte [7:0]             selected byte (00 for indexes past the word)
module ans_byte_sel
  import ans_serializer_pkg::*;
#(
  parameter int N           = 32,
  parameter int NBYTES_LOG2 = 2
) (
  input  logic [N-1:0]           i_word,
  input  logic [NBYTES_LOG2-1:0] i_idx,
  output logic [7:0]             o_byte
);

  always_comb begin
    o_byte = 8'h00;
    for (int k = 0; k < N / 8; k++) begin
      if (int'(i_idx) == k) begin
        o_byte = i_word[N-1-8*k -: 8];
      end
    end
  end

endmodule

// File: rtl/ans_serializer.sv
// ans_serializer
//   Sends an N-bit result word to a byte uart, MSB-first, one byte per
//   transmit strobe, pacing itself on the uart busy flag.
//   Optional feature macro: ANS_CHECKSUM_EN appends an XOR checksum byte.
//   Ports:
//     clk              clock, all state on rising edge
//     rst              asynchronous active-low reset
//     rx_valid         one-cycle pulse, rx_bytes holds a word to send
//     rx_bytes [N-1:0] result word (sampled only on acceptance)
//     is_transmitting  uart busy flag
//     tx_byte  [7:0]   byte presented to the uart
//     tx_valid         one-cycle transmit strobe
//     busy             frame in progress
//     dropped          one-cycle pulse: a word arrived while not idle
module ans_serializer
  import ans_serializer_pkg::*;
#(
  parameter int N           = 32,
  parameter int NBYTES_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [N-1:0] rx_bytes,
  input  logic         is_transmitting,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  output logic         busy,
  output logic         dropped
);

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_START_TIMEOUT - 1);

  AnsState                r_state;
  AnsState                w_stateNext;
  logic [N-1:0]           r_word;
  logic [NBYTES_LOG2-1:0] r_byteIdx;
  logic [2:0]             r_waitCnt;
  logic                   r_txValid;
  logic                   r_dropped;
  logic                   w_capture;
  logic                   w_strobe;
  logic                   w_advance;
  logic                   w_lastIdx;
  logic [7:0]             w_dataByte;
`ifdef ANS_CHECKSUM_EN
  logic [7:0]             r_csum;
  logic                   r_csumPhase;
`endif

  ans_byte_sel #(
    .N           (N),
    .NBYTES_LOG2 (NBYTES_LOG2)
  ) u_byteSel (
    .i_word (r_word),
    .i_idx  (r_byteIdx),
    .o_byte (w_dataByte)
  );

  assign w_lastIdx = (int'(r_byteIdx) == N / 8 - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Acceptance only happens in IDLE, so a word arriving during the final
  // NEXT cycle is dropped even though busy falls on that same edge.
  always_comb begin
    w_stateNext = r_state;
    w_capture   = 1'b0;
    w_strobe    = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          w_capture   = 1'b1;
          w_stateNext = STROBE;
        end
      end
      STROBE: begin
        if (!is_transmitting) begin
          w_strobe    = 1'b1;
          w_stateNext = WAIT_START;
        end
      end
      WAIT_START: begin
        // A uart that never reports busy must not stall the frame.
        if (is_transmitting || (r_waitCnt == WAIT_LAST)) begin
          w_stateNext = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!is_transmitting) begin
          w_stateNext = NEXT;
        end
      end
      NEXT: begin
`ifdef ANS_CHECKSUM_EN
        if (r_csumPhase) begin
          w_stateNext = IDLE;
        end else if (w_lastIdx) begin
          w_stateNext = CSUM;
        end else begin
          w_advance   = 1'b1;
          w_stateNext = STROBE;
        end
`else
        if (w_lastIdx) begin
          w_stateNext = IDLE;
        end else begin
          w_advance   = 1'b1;
          w_stateNext = STROBE;
        end
`endif
      end
`ifdef ANS_CHECKSUM_EN
      CSUM: begin
        if (!is_transmitting) begin
          w_strobe    = 1'b1;
          w_stateNext = WAIT_START;
        end
      end
`endif
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // The index only advances from NEXT when it is below the last byte,
  // so it can never wrap past N/8-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word    <= '0;
      r_byteIdx <= '0;
      r_waitCnt <= 3'd0;
      r_txValid <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_txValid <= w_strobe;
      r_dropped <= rx_valid && (r_state != IDLE);
      if (w_capture) begin
        r_word    <= rx_bytes;
        r_byteIdx <= '0;
      end else if (w_advance) begin
        r_byteIdx <= r_byteIdx + 1'b1;
      end
      if (r_state == WAIT_START) begin
        r_waitCnt <= r_waitCnt + 3'd1;
      end else begin
        r_waitCnt <= 3'd0;
      end
    end
  end

`ifdef ANS_CHECKSUM_EN
  // The checksum folds in each data byte as it is strobed; the strobe
  // of the checksum itself only marks that the trailer is under way.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_csum      <= 8'h00;
      r_csumPhase <= 1'b0;
    end else if (w_capture) begin
      r_csum      <= CSUM_SEED;
      r_csumPhase <= 1'b0;
    end else if (w_strobe) begin
      if (r_state == CSUM) begin
        r_csumPhase <= 1'b1;
      end else begin
        r_csum <= r_csum ^ w_dataByte;
      end
    end
  end
`endif

  // tx_byte follows the current byte in every non-idle state, which keeps
  // it stable from STROBE through WAIT_DONE and forces 00 when idle.
  always_comb begin
    tx_byte = 8'h00;
    if (r_state != IDLE) begin
`ifdef ANS_CHECKSUM_EN
      if ((r_state == CSUM) || r_csumPhase) begin
        tx_byte = r_csum;
      end else begin
        tx_byte = w_dataByte;
      end
`else
      tx_byte = w_dataByte;
`endif
    end
  end

  assign tx_valid = r_txValid;
  assign dropped  = r_dropped;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_ans_serializer.sv
// tb_ans_serializer
//   Self-checking bench for ans_serializer with a behavioural uart model.
//   Expected bytes are queued when a word is offered and compared as the
//   serializer strobes them out. Honours ANS_CHECKSUM_EN when defined.
module tb_ans_serializer;

  localparam int N           = 32;
  localparam int NBYTES_LOG2 = 2;
  localparam int NB          = N / 8;
`ifdef ANS_CHECKSUM_EN
  localparam int FRAME = NB + 1;
`else
  localparam int FRAME = NB;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         rxValid;
  logic [N-1:0] rxBytes;
  logic         isTransmitting = 1'b0;
  logic [7:0]   txByte;
  logic         txValid;
  logic         busy;
  logic         dropped;

  ans_serializer #(
    .N           (N),
    .NBYTES_LOG2 (NBYTES_LOG2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_valid        (rxValid),
    .rx_bytes        (rxBytes),
    .is_transmitting (isTransmitting),
    .tx_byte         (txByte),
    .tx_valid        (txValid),
    .busy            (busy),
    .dropped         (dropped)
  );

  always #5 clk = ~clk;

  int         checks          = 0;
  int         errors          = 0;
  logic [7:0] expQ[$];
  int         strobeCount     = 0;
  int         dropCount       = 0;
  int         expDrops        = 0;
  int         cycle           = 0;
  int         lastStrobeCycle = -100;
  int         uartCnt         = 0;
  int         uartCycles      = 10;
  logic       uartNever       = 1'b0;
  logic       holdHigh        = 1'b0;
  logic [7:0] lastByte        = 8'h00;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Monitor and uart model share one block so the byte just strobed is
  // recorded before the uart starts counting down its transmission.
  always @(negedge clk) begin
    cycle++;
    if (txValid) begin
      if (expQ.size() == 0) begin
        checkOutput("strobeWithEmptyQueue", 1, 0);
      end else begin
        checkOutput("txByte", txByte, expQ.pop_front());
      end
      checkOutput("strobeSpacing", (cycle - lastStrobeCycle) >= 3, 1);
      lastStrobeCycle = cycle;
      lastByte        = txByte;
      strobeCount++;
    end else if (busy && (uartCnt != 0)) begin
      checkOutput("txByteHold", txByte, lastByte);
    end
    if (!busy) begin
      checkOutput("txByteIdle", txByte, 8'h00);
    end
    if (dropped) begin
      dropCount++;
    end
    if (txValid && !uartNever) begin
      uartCnt = uartCycles;
    end else if (uartCnt > 0) begin
      uartCnt--;
    end
    isTransmitting = holdHigh || (uartCnt != 0);
  end

  // Called at a falling edge; offers the word for one cycle.
  task automatic applyStimulus(input logic [N-1:0] word);
    logic [N-1:0] tmp;
`ifdef ANS_CHECKSUM_EN
    logic [7:0] csum;
    csum = 8'h00;
`endif
    tmp = word;
    for (int k = 0; k < NB; k++) begin
      expQ.push_back(tmp[N-1 -: 8]);
`ifdef ANS_CHECKSUM_EN
      csum = csum ^ tmp[N-1 -: 8];
`endif
      tmp = tmp << 8;
    end
`ifdef ANS_CHECKSUM_EN
    expQ.push_back(csum);
`endif
    rxBytes = word;
    rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
    rxBytes = ~word;
    #1 checkOutput("busyAfterAccept", busy, 1'b1);
  endtask

  task automatic waitStrobes(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while ((strobeCount < target) && (n < budget)) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_strobesReached"}, strobeCount >= target, 1);
  endtask

  task automatic waitUartIdle(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while (isTransmitting && (n < budget)) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_uartIdle"}, n < budget, 1);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while ((busy || (expQ.size() != 0)) && (n < budget)) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_done"}, n < budget, 1);
    checkOutput({tag, "_queueEmpty"}, expQ.size(), 0);
    checkOutput({tag, "_drops"}, dropCount, expDrops);
    expQ.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s0;
    int s1;
    rst     = 1'b1;
    rxValid = 1'b0;
    rxBytes = '0;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("resetTxValid", txValid, 1'b0);
    checkOutput("resetTxByte", txByte, 8'h00);
    checkOutput("resetBusy", busy, 1'b0);
    checkOutput("resetDropped", dropped, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] basic frame DEADBEEF");
    s0 = strobeCount;
    @(negedge clk);
    applyStimulus(32'hDEADBEEF);
    waitIdle("frameA", 400);
    checkOutput("frameA_strobes", strobeCount - s0, FRAME);
    checkOutput("frameA_uartIdleAtBusyFall", isTransmitting, 1'b0);

    $display("[TB] word offered during second byte");
    s0 = strobeCount;
    @(negedge clk);
    applyStimulus(32'hDEADBEEF);
    waitStrobes("frameB", s0 + 2, 200);
    @(negedge clk);
    rxBytes = 32'h12345678;
    rxValid = 1'b1;
    expDrops++;
    @(negedge clk);
    rxValid = 1'b0;
    #1 checkOutput("droppedPulse", dropped, 1'b1);
    @(negedge clk);
    #1 checkOutput("droppedOneCycle", dropped, 1'b0);
    waitIdle("frameB", 400);
    checkOutput("frameB_strobes", strobeCount - s0, FRAME);

    $display("[TB] word offered in the final NEXT cycle");
    s0 = strobeCount;
    @(negedge clk);
    applyStimulus(32'hA5C30F96);
    waitStrobes("frameC", s0 + FRAME, 400);
    waitUartIdle("frameC", 40);
    @(negedge clk);
    rxBytes = 32'h13579BDF;
    rxValid = 1'b1;
    expDrops++;
    @(negedge clk);
    rxValid = 1'b0;
    #1;
    checkOutput("lateDropPulse", dropped, 1'b1);
    checkOutput("lateDropBusy", busy, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    checkOutput("lateDropNoFrame", strobeCount - s0, FRAME);
    checkOutput("lateDropQueueEmpty", expQ.size(), 0);
    checkOutput("lateDropCount", dropCount, expDrops);

    $display("[TB] reset during third byte");
    s0 = strobeCount;
    @(negedge clk);
    applyStimulus(32'hDEADBEEF);
    waitStrobes("frameD", s0 + 3, 300);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("rstAsyncTxValid", txValid, 1'b0);
    checkOutput("rstAsyncTxByte", txByte, 8'h00);
    checkOutput("rstAsyncBusy", busy, 1'b0);
    checkOutput("rstAsyncDropped", dropped, 1'b0);
    expQ.delete();
    s1 = strobeCount;
    waitUartIdle("frameD", 40);
    repeat (2) @(negedge clk);
    checkOutput("noStrobeAfterReset", strobeCount - s1, 0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(32'h00000001);
    waitIdle("frameD", 400);
    checkOutput("frameD_strobes", strobeCount - s1, FRAME);

    $display("[TB] uart busy when the word arrives");
    holdHigh = 1'b1;
    repeat (2) @(negedge clk);
    s0 = strobeCount;
    @(negedge clk);
    applyStimulus(32'hDEADBEEF);
    repeat (20) @(negedge clk);
    #1;
    checkOutput("holdNoStrobe", strobeCount - s0, 0);
    checkOutput("holdBusy", busy, 1'b1);
    holdHigh = 1'b0;
    waitIdle("frameE", 400);
    checkOutput("frameE_strobes", strobeCount - s0, FRAME);

    $display("[TB] uart never reports busy");
    uartNever = 1'b1;
    s0 = strobeCount;
    @(negedge clk);
    applyStimulus(32'hDEADBEEF);
    waitIdle("frameF", 400);
    checkOutput("frameF_strobes", strobeCount - s0, FRAME);
    uartNever = 1'b0;

    $display("[TB] random words and uart speeds");
    for (int i = 0; i < 3; i++) begin
      uartCycles = $urandom_range(1, 12);
      s0 = strobeCount;
      @(negedge clk);
      applyStimulus($urandom);
      waitIdle("frameR", 400);
      checkOutput("frameR_strobes", strobeCount - s0, FRAME);
    end
    uartCycles = 10;

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
